// File: rtl/cmd_pkg.sv
// Shared command-path definitions: packet layout, framing constants and
// the state encodings used by the UART receive front end.
// Optional build macro: CMD_CHECKSUM_EN adds a trailing XOR checksum byte
// to every command frame.
package cmd_pkg;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_packet_t;

    localparam logic [7:0] CMD_SYNC     = 8'hA5;
    localparam logic [7:0] CMD_OP_READ  = 8'h52;
    localparam logic [7:0] CMD_OP_WRITE = 8'h57;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HUNT,
        P_OPC,
        P_ADDR,
        P_DATA,
`ifdef CMD_CHECKSUM_EN
        P_CSUM,
`endif
        P_PUSH
    } parse_state_t;

    // Frame check byte: XOR of the three payload bytes.
    function automatic logic [7:0] cmd_checksum(input logic [7:0] opcode,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
        return opcode ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser plus an oversampled 8N1 bit engine.
// Emits a one-cycle byte_valid with byte_data, or a one-cycle frame_err
// when the stop bit is sampled low.
module uart_rx
    import cmd_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_x16_tick,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] tick_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_q;
    logic [7:0]       shift_next;
    logic             byte_valid_next;
    logic             frame_err_next;

    // Bring the asynchronous line into the clk domain; idle-high reset value
    // keeps a reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit engine state, counters, shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_q    <= shift_next;
            byte_valid <= byte_valid_next;
            frame_err  <= frame_err_next;
        end
    end

    // Everything advances only on oversample ticks; samples land mid-bit
    // because the start bit is re-checked half a bit after the edge.
    always_comb begin
        state_next      = state;
        tick_cnt_next   = tick_cnt;
        bit_idx_next    = bit_idx;
        shift_next      = shift_q;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        if (baud_x16_tick) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state_next    = RX_START;
                        tick_cnt_next = '0;
                    end
                end
                RX_START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt_next = '0;
                        bit_idx_next  = '0;
                        state_next    = rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt_next = '0;
                        shift_next    = {rx_sync, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_next = RX_STOP;
                        end else begin
                            bit_idx_next = bit_idx + 3'd1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt_next   = '0;
                        state_next      = RX_IDLE;
                        byte_valid_next = rx_sync;
                        frame_err_next  = !rx_sync;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Inbound command front end: frames UART bytes into cmd_packet_t commands
// and writes each legal one into the command FIFO. Malformed, timed-out and
// unbufferable frames are dropped and counted in a saturating drop_cnt.
// Optional build macro: CMD_CHECKSUM_EN (five-byte frame with XOR check).
module uart_cmd_rx
    import cmd_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int TIMEOUT_TICKS = 2560
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_x16_tick,
    input  logic        rx,
    input  logic        cmd_fifo_full,
    output cmd_packet_t cmd_fifo_wr_data,
    output logic        cmd_fifo_wr_en,
    output logic        frame_err,
    output logic [7:0]  drop_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

    logic         byte_valid;
    logic [7:0]   byte_data;
    parse_state_t state;
    parse_state_t state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic         timeout;
    logic         drop_inc;
    logic         load_op;
    logic         load_addr;
    logic         load_pkt;
    logic [7:0]   op_q;
    logic [7:0]   addr_q;
    cmd_packet_t  pkt_next;
`ifdef CMD_CHECKSUM_EN
    logic         load_data;
    logic [7:0]   data_q;
`endif

    uart_rx #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_uart_rx (
        .clk          (clk),
        .rst          (rst),
        .baud_x16_tick(baud_x16_tick),
        .rx           (rx),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .frame_err    (frame_err)
    );

    // Parser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= P_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Inter-byte timer: runs only while a frame is open, restarts per byte.
    always_ff @(posedge clk) begin
        if (rst || state == P_HUNT || byte_valid) begin
            tmo_cnt <= '0;
        end else if (baud_x16_tick) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = (state != P_HUNT) && (state != P_PUSH) &&
                     baud_x16_tick && (tmo_cnt == TMO_LAST);

    // Next-state and strobes; frame errors and timeouts override the byte
    // handling, but a byte arriving with a timeout still wins.
    always_comb begin
        state_next     = state;
        cmd_fifo_wr_en = 1'b0;
        drop_inc       = 1'b0;
        load_op        = 1'b0;
        load_addr      = 1'b0;
        load_pkt       = 1'b0;
`ifdef CMD_CHECKSUM_EN
        load_data      = 1'b0;
`endif
        case (state)
            P_HUNT: begin
                if (byte_valid && byte_data == CMD_SYNC) begin
                    state_next = P_OPC;
                end
            end
            P_OPC: begin
                if (byte_valid) begin
                    if (byte_data == CMD_OP_READ || byte_data == CMD_OP_WRITE) begin
                        load_op    = 1'b1;
                        state_next = P_ADDR;
                    end else begin
                        drop_inc   = 1'b1;
                        state_next = P_HUNT;
                    end
                end
            end
            P_ADDR: begin
                if (byte_valid) begin
                    load_addr  = 1'b1;
                    state_next = P_DATA;
                end
            end
            P_DATA: begin
                if (byte_valid) begin
`ifdef CMD_CHECKSUM_EN
                    load_data  = 1'b1;
                    state_next = P_CSUM;
`else
                    load_pkt   = 1'b1;
                    state_next = P_PUSH;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            P_CSUM: begin
                if (byte_valid) begin
                    if (byte_data == cmd_checksum(op_q, addr_q, data_q)) begin
                        load_pkt   = 1'b1;
                        state_next = P_PUSH;
                    end else begin
                        drop_inc   = 1'b1;
                        state_next = P_HUNT;
                    end
                end
            end
`endif
            P_PUSH: begin
                if (cmd_fifo_full) begin
                    drop_inc = 1'b1;
                end else begin
                    cmd_fifo_wr_en = 1'b1;
                end
                state_next = P_HUNT;
            end
            default: state_next = P_HUNT;
        endcase

        if (frame_err) begin
            if (state != P_HUNT && state != P_PUSH) begin
                drop_inc = 1'b1;
            end
            state_next = P_HUNT;
        end else if (timeout && !byte_valid) begin
            drop_inc   = 1'b1;
            state_next = P_HUNT;
        end
    end

`ifdef CMD_CHECKSUM_EN
    assign pkt_next = '{opcode: op_q, addr: addr_q, data: data_q};
`else
    assign pkt_next = '{opcode: op_q, addr: addr_q, data: byte_data};
`endif

    // Field capture; the output packet only changes when a frame commits,
    // so it stays stable across the write strobe and until the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q             <= '0;
            addr_q           <= '0;
            cmd_fifo_wr_data <= '0;
`ifdef CMD_CHECKSUM_EN
            data_q           <= '0;
`endif
        end else begin
            if (load_op) begin
                op_q <= byte_data;
            end
            if (load_addr) begin
                addr_q <= byte_data;
            end
`ifdef CMD_CHECKSUM_EN
            if (load_data) begin
                data_q <= byte_data;
            end
`endif
            if (load_pkt) begin
                cmd_fifo_wr_data <= pkt_next;
            end
        end
    end

    // Saturating discard counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_inc && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
